// File: rtl/sb_cfg_if.sv
// Requester handshakes and the shared switch-box config bus of sb_cfg_arbiter.
interface sb_cfg_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_addr;
    logic [31:0] req1_data;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_en;
    logic        busy;
    logic        err_sticky;
    logic [15:0] write_count;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output config_addr, config_data, config_en,
        output busy, err_sticky, write_count
    );

    // Requester / observer side.
    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  config_addr, config_data, config_en,
        input  busy, err_sticky, write_count
    );
endinterface

// File: rtl/sb_cfg_arbiter.sv
// Two-requester round-robin arbiter onto a shared switch-box config bus.
// One write is issued per grant, followed by GAP_CYCLES idle cycles.
module sb_cfg_arbiter #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned MAX_REG    = 2
) (
    input logic     clk,
    input logic     reset,
    sb_cfg_if.slave bus
);

    localparam logic [7:0] MaxIdx  = 8'(MAX_REG);
    localparam logic [3:0] GapInit = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic [3:0]  gap_cnt_q;
    logic        cfg_en_q;
    logic [31:0] cfg_addr_q;
    logic [31:0] cfg_data_q;
    logic        err_q;
    logic [15:0] write_count_q;

    logic        grant;
    logic        accept;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic        sel_legal;

    // Grant selection: a lone requester wins, a tie goes to whoever did not win last.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
        sel_addr  = grant ? bus.req1_addr : bus.req0_addr;
        sel_data  = grant ? bus.req1_data : bus.req0_data;
        sel_legal = (sel_addr[31:24] <= MaxIdx);
        accept    = (state_q == StIdle) && !reset && (bus.req0_valid || bus.req1_valid);
    end

    assign bus.req0_ready  = accept && !grant;
    assign bus.req1_ready  = accept && grant;
    assign bus.config_addr = cfg_addr_q;
    assign bus.config_data = cfg_data_q;
    assign bus.config_en   = cfg_en_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.err_sticky  = err_q;
    assign bus.write_count = write_count_q;

    // Arbitration FSM with registered bus outputs; config_en is set on the accept edge
    // so it is high exactly during ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            gap_cnt_q     <= 4'd0;
            cfg_en_q      <= 1'b0;
            cfg_addr_q    <= 32'd0;
            cfg_data_q    <= 32'd0;
            err_q         <= 1'b0;
            write_count_q <= 16'd0;
        end else begin
            cfg_en_q <= 1'b0;
            if (cfg_en_q && (write_count_q != 16'hFFFF)) begin
                write_count_q <= write_count_q + 16'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        last_grant_q <= grant;
                        state_q      <= StIssue;
                        if (sel_legal) begin
                            cfg_en_q   <= 1'b1;
                            cfg_addr_q <= sel_addr;
                            cfg_data_q <= sel_data;
                        end else begin
                            // Out-of-range index: drop the write, bus keeps old values.
                            err_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    gap_cnt_q <= GapInit;
                    state_q   <= (GAP_CYCLES == 0) ? StIdle : StGap;
                end
                StGap: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_cfg_arbiter.sv
// Scoreboard bench for sb_cfg_arbiter: a timing-level model predicts grants and
// bus writes, a monitor compares the config bus against the expected queue.
module tb_sb_cfg_arbiter;

    localparam int Gap = 1;

    logic clk = 1'b0;
    logic reset;
    logic reset0;
    always #5 clk = ~clk;

    sb_cfg_if bus ();
    sb_cfg_if bus0 ();

    sb_cfg_arbiter #(.GAP_CYCLES(Gap), .MAX_REG(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sb_cfg_arbiter #(.GAP_CYCLES(0), .MAX_REG(2)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic rst_at_edge = 1'b1;
    logic done0 = 1'b0;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    // Model: time of next free IDLE cycle, last winner, error flag, committed count.
    logic m_last;
    int   m_free;
    logic m_err;
    int   m_cnt;
    int   m_inc_at;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rand_addr(input int unsigned max_idx);
        logic [31:0] a;
        a = $urandom;
        a[31:24] = 8'($urandom_range(0, max_idx));
        return a;
    endfunction

    // Drop expected writes that a freshly asserted reset will abort.
    task automatic flush();
        while (sb_q.size() > 0 && sb_q[sb_q.size() - 1].due > cyc) begin
            void'(sb_q.pop_back());
        end
    endtask

    // Per-cycle model step: check status outputs and readies, predict handshakes.
    task automatic cycle_check(output logic hs0, output logic hs1);
        logic        idle;
        logic        g;
        logic [31:0] a;
        logic [31:0] d;
        @(negedge clk);
        hs0 = 1'b0;
        hs1 = 1'b0;
        if (rst_at_edge) begin
            m_last = 1'b1; m_free = 0; m_err = 1'b0; m_cnt = 0; m_inc_at = -1;
        end else if (m_inc_at == cyc) begin
            if (m_cnt < 65535) m_cnt++;
            m_inc_at = -1;
        end
        check("busy", 32'(bus.busy), 32'(cyc < m_free));
        check("err_sticky", 32'(bus.err_sticky), 32'(m_err));
        check("write_count", 32'(bus.write_count), 32'(m_cnt));
        idle = !reset && (cyc >= m_free);
        g = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
        check("req0_ready", 32'(bus.req0_ready), 32'(idle && bus.req0_valid && !g));
        check("req1_ready", 32'(bus.req1_ready), 32'(idle && bus.req1_valid && g));
        if (idle && (bus.req0_valid || bus.req1_valid)) begin
            a = g ? bus.req1_addr : bus.req0_addr;
            d = g ? bus.req1_data : bus.req0_data;
            if (a[31:24] <= 8'd2) begin
                sb_q.push_back('{due: cyc + 1, addr: a, data: d});
                m_inc_at = cyc + 2;
            end else begin
                m_err = 1'b1;
            end
            m_last = g;
            m_free = cyc + 2 + Gap;
            hs0 = !g;
            hs1 = g;
        end
    endtask

    // Modes: 0 random, 1 both always valid (legal), 2 idle, 3 reset, 5 reset with req0 valid.
    task automatic drive(input int mode, input logic hs0, input logic hs1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        case (mode)
            0: begin
                if ($urandom_range(0, 59) == 0) begin
                    reset = 1'b1;
                    flush();
                end
                if (hs0 || !bus.req0_valid) begin
                    bus.req0_valid = ($urandom_range(0, 2) != 0);
                    bus.req0_addr  = rand_addr(4);
                    bus.req0_data  = $urandom;
                end
                if (hs1 || !bus.req1_valid) begin
                    bus.req1_valid = ($urandom_range(0, 2) != 0);
                    bus.req1_addr  = rand_addr(4);
                    bus.req1_data  = $urandom;
                end
            end
            1: begin
                if (hs0 || !bus.req0_valid) begin
                    bus.req0_valid = 1'b1;
                    bus.req0_addr  = rand_addr(2);
                    bus.req0_data  = $urandom;
                end
                if (hs1 || !bus.req1_valid) begin
                    bus.req1_valid = 1'b1;
                    bus.req1_addr  = rand_addr(2);
                    bus.req1_data  = $urandom;
                end
            end
            3: begin
                reset = 1'b1;
                flush();
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            5: begin
                reset = 1'b1;
                flush();
                bus.req0_valid = 1'b1;
                bus.req0_addr  = 32'h0100_0000;
                bus.req0_data  = 32'hA5A5_0001;
                bus.req1_valid = 1'b0;
            end
            default: begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        endcase
    endtask

    // Monitor: pops an expected write whenever one is due, otherwise the bus must hold.
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_data = 32'd0;
    always @(negedge clk) begin
        if (rst_at_edge) begin
            exp_addr = 32'd0;
            exp_data = 32'd0;
            check("config_en after reset", 32'(bus.config_en), 32'd0);
        end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            check("config_en strobe", 32'(bus.config_en), 32'd1);
            exp_addr = sb_q[0].addr;
            exp_data = sb_q[0].data;
            void'(sb_q.pop_front());
        end else begin
            check("config_en quiet", 32'(bus.config_en), 32'd0);
        end
        check("config_addr", bus.config_addr, exp_addr);
        check("config_data", bus.config_data, exp_data);
    end

    // GAP_CYCLES=0 instance: back-to-back writes and count saturation.
    initial begin
        reset0 = 1'b1;
        bus0.req0_valid = 1'b0; bus0.req0_addr = 32'd0; bus0.req0_data = 32'd0;
        bus0.req1_valid = 1'b0; bus0.req1_addr = 32'd0; bus0.req1_data = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset0 = 1'b0;
        @(negedge clk);
        check("g0 reset busy", 32'(bus0.busy), 32'd0);
        check("g0 reset count", 32'(bus0.write_count), 32'd0);
        @(posedge clk);
        #1;
        bus0.req0_valid = 1'b1;
        bus0.req0_addr  = 32'h0100_0000;
        bus0.req0_data  = 32'hC0DE_0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("g0 ready pattern", 32'(bus0.req0_ready), 32'(c % 2 == 0));
            check("g0 en pattern", 32'(bus0.config_en), 32'(c % 2 == 1));
            if (c % 2 == 1) check("g0 data", bus0.config_data, 32'hC0DE_0000 + 32'(c / 2));
            @(posedge clk);
            #1;
            if (c == 4) bus0.req0_valid = 1'b0;
            else if (c % 2 == 0) bus0.req0_data = 32'hC0DE_0000 + 32'(c / 2 + 1);
        end
        @(negedge clk);
        check("g0 count after 3", 32'(bus0.write_count), 32'd3);
        force dut0.write_count_q = 16'hFFFE;
        @(negedge clk);
        release dut0.write_count_q;
        @(posedge clk);
        #1 bus0.req0_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2 || c == 4) check("g0 saturate", 32'(bus0.write_count), 32'h0000_FFFF);
            @(posedge clk);
            #1;
            if (c == 2) bus0.req0_valid = 1'b0;
        end
        done0 = 1'b1;
    end

    initial begin
        logic h0;
        logic h1;
        int   n;
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_addr = 32'd0; bus.req0_data = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_addr = 32'd0; bus.req1_data = 32'd0;
        m_last = 1'b1; m_free = 0; m_err = 1'b0; m_cnt = 0; m_inc_at = -1;
        for (int i = 0; i < 3; i++) begin
            cycle_check(h0, h1);
            drive(3, h0, h1);
        end
        // Contention straight out of reset: 8 alternating grants.
        n = 0;
        for (int i = 0; i < 100 && n < 8; i++) begin
            cycle_check(h0, h1);
            n = n + int'(h0) + int'(h1);
            drive((n >= 8) ? 2 : 1, h0, h1);
        end
        check("contention handshakes in budget", 32'(n), 32'd8);
        for (int i = 0; i < 6; i++) begin
            cycle_check(h0, h1);
            drive(2, h0, h1);
        end
        check("contention write_count", 32'(bus.write_count), 32'd8);
        // Randomized traffic with illegal indices and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle_check(h0, h1);
            drive(0, h0, h1);
        end
        for (int i = 0; i < 6; i++) begin
            cycle_check(h0, h1);
            drive(2, h0, h1);
        end
        // Reset coinciding with a would-be handshake.
        cycle_check(h0, h1);
        drive(5, h0, h1);
        cycle_check(h0, h1);
        drive(2, h0, h1);
        cycle_check(h0, h1);
        check("post-reset write_count", 32'(bus.write_count), 32'd0);
        check("post-reset config_en", 32'(bus.config_en), 32'd0);
        check("post-reset config_addr", bus.config_addr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(2, h0, h1);
            cycle_check(h0, h1);
        end
        for (int i = 0; i < 2000 && !done0; i++) @(posedge clk);
        check("gap0 sequence finished", 32'(done0), 32'd1);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
